// File: rtl/haar_pkg.sv
// -----------------------------------------------------------------------------
// haar_pkg
// Shared definitions for the Haar cascade stage sequencer:
//   state_t          - sequencer FSM encoding (IDLE -> STREAM -> DONE)
//   words_per_stage  - memory words occupied by one cascade stage
//   addr_bits        - address width needed to cover a given memory depth
// -----------------------------------------------------------------------------
package haar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // A stage is all of its trees back to back, followed by its threshold group.
    function automatic int words_per_stage(input int classifiers,
                                           input int params_per_classifier,
                                           input int thresholds);
        return classifiers * params_per_classifier + thresholds;
    endfunction

    // Never return zero so a degenerate one-word memory still has an address bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/haar_stage_rom.sv
// -----------------------------------------------------------------------------
// stage_rom
// Synchronous single-port ROM holding the cascade parameters of every stage.
// Ports:
//   clk    - read clock (rising edge)
//   rd_en  - read enable; q keeps its previous word while low
//   addr   - word address
//   q      - registered read data, valid one cycle after an enabled read
// -----------------------------------------------------------------------------
module stage_rom #(
    parameter int    DEPTH      = 772,
    parameter int    AW         = 10,
    parameter int    DW         = 12,
    parameter string INIT_FILE  = "memory.mif"
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:DEPTH-1];

    // The read register only loads on rd_en, which is what lets the sequencer
    // hold a word on its output while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/haar_stage_sequencer.sv
// -----------------------------------------------------------------------------
// haar_stage_sequencer
// Streams the parameter words of one or more Haar cascade stages out of the
// stage ROM with a valid/ready handshake, tagging each word with its stage,
// tree and word offset plus end-of-tree / end-of-stage markers.
// Ports:
//   clk_fpga, reset_fpga        - clock, asynchronous active-low reset
//   i_start, i_stage_sel        - start request and first stage to stream
//   i_single_stage              - 1: only the selected stage, 0: through the last
//   i_abort                     - return to IDLE immediately, no completion
//   i_ready                     - consumer accepts o_data
//   o_valid, o_data             - output word and its qualifier
//   o_stage_index, o_tree_index, o_param_index - position of the word
//   o_is_threshold, o_end_tree, o_end_stage    - word markers
//   o_done, o_busy, o_err       - completion pulse, activity, rejected start
// -----------------------------------------------------------------------------
module haar_stage_sequencer
    import haar_pkg::*;
#(
    parameter int    ADDR_WIDTH               = 10,
    parameter int    DATA_WIDTH               = 12,
    parameter int    NUM_STAGES               = 4,
    parameter int    NUM_CLASSIFIERS_STAGE    = 10,
    parameter int    NUM_PARAM_PER_CLASSIFIER = 19,
    parameter int    NUM_STAGE_THRESHOLD      = 3,
    parameter string FILE_STAGE_MEM           = "memory.mif"
) (
    input  logic                  clk_fpga,
    input  logic                  reset_fpga,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_stage_sel,
    input  logic                  i_single_stage,
    input  logic                  i_abort,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_stage_index,
    output logic [ADDR_WIDTH-1:0] o_tree_index,
    output logic [ADDR_WIDTH-1:0] o_param_index,
    output logic                  o_is_threshold,
    output logic                  o_end_tree,
    output logic                  o_end_stage,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int WPS   = words_per_stage(NUM_CLASSIFIERS_STAGE,
                                           NUM_PARAM_PER_CLASSIFIER,
                                           NUM_STAGE_THRESHOLD);
    localparam int DEPTH = NUM_STAGES * WPS;
    localparam int AW    = addr_bits(DEPTH);

    localparam logic [AW-1:0]         WPS_A      = AW'(WPS);
    localparam logic [ADDR_WIDTH:0]   STAGE_LIM  = (ADDR_WIDTH + 1)'(NUM_STAGES);
    localparam logic [ADDR_WIDTH-1:0] STAGE_LAST = ADDR_WIDTH'(NUM_STAGES - 1);
    localparam logic [ADDR_WIDTH-1:0] THR_TREE   = ADDR_WIDTH'(NUM_CLASSIFIERS_STAGE);
    localparam logic [ADDR_WIDTH-1:0] P_LAST     = ADDR_WIDTH'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [ADDR_WIDTH-1:0] T_LAST     = ADDR_WIDTH'(NUM_STAGE_THRESHOLD - 1);

    state_t                  state;
    state_t                  next_state;
    logic                    sel_in_range;
    logic                    start_ok;
    logic                    start_bad;
    logic                    final_xfer;
    logic                    advance;
    logic                    loaded;
    logic                    fetch_active;
    logic [ADDR_WIDTH-1:0]   last_stage;
    logic [ADDR_WIDTH-1:0]   f_stage;
    logic [ADDR_WIDTH-1:0]   f_tree;
    logic [ADDR_WIDTH-1:0]   f_param;
    logic                    f_thr;
    logic                    f_end_tree;
    logic                    f_end_stage;
    logic [AW-1:0]           addr;
    logic [AW-1:0]           base_addr;
    logic [DATA_WIDTH-1:0]   rom_q;

    // The f_* counters describe the word being fetched; the o_* registers
    // describe the word currently presented. The threshold group is
    // recognised by the tree counter sitting one past the last tree.
    assign f_thr       = (f_tree == THR_TREE);
    assign f_end_tree  = !f_thr && (f_param == P_LAST);
    assign f_end_stage = f_thr && (f_param == T_LAST);
    assign base_addr   = AW'(f_stage) * WPS_A;

    assign sel_in_range = ({1'b0, i_stage_sel} < STAGE_LIM);
    assign start_ok     = (state == ST_IDLE) && i_start && !i_abort && sel_in_range;
    assign start_bad    = (state == ST_IDLE) && i_start && !i_abort && !sel_in_range;
    assign final_xfer   = o_valid && i_ready && o_end_stage && (o_stage_index == last_stage);

    // A new word is fetched whenever the output slot is empty or being
    // emptied this cycle, so the stream runs bubble-free under full ready.
    assign advance = (state == ST_STREAM) && fetch_active && !i_abort &&
                     (!o_valid || i_ready);

    assign o_data = o_valid ? rom_q : '0;
    assign o_busy = (state != ST_IDLE);
    assign o_done = (state == ST_DONE);

    stage_rom #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .DW        (DATA_WIDTH),
        .INIT_FILE (FILE_STAGE_MEM)
    ) u_rom (
        .clk   (clk_fpga),
        .rd_en (advance),
        .addr  (addr),
        .q     (rom_q)
    );

    // State register.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides everything else.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start_ok)   next_state = ST_STREAM;
            ST_STREAM: if (final_xfer) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (i_abort) begin
            next_state = ST_IDLE;
        end
    end

    // Fetch counters and output word registers. The first STREAM cycle only
    // loads the base address, which keeps the stage multiply off the start
    // path and gives the two-cycle start-to-valid latency.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            o_valid        <= 1'b0;
            o_stage_index  <= '0;
            o_tree_index   <= '0;
            o_param_index  <= '0;
            o_is_threshold <= 1'b0;
            o_end_tree     <= 1'b0;
            o_end_stage    <= 1'b0;
            o_err          <= 1'b0;
            loaded         <= 1'b0;
            fetch_active   <= 1'b0;
            last_stage     <= '0;
            f_stage        <= '0;
            f_tree         <= '0;
            f_param        <= '0;
            addr           <= '0;
        end else begin
            o_err <= start_bad;
            if (i_abort) begin
                o_valid      <= 1'b0;
                fetch_active <= 1'b0;
                loaded       <= 1'b0;
            end else if (start_ok) begin
                f_stage      <= i_stage_sel;
                last_stage   <= i_single_stage ? i_stage_sel : STAGE_LAST;
                loaded       <= 1'b0;
                fetch_active <= 1'b0;
            end else if (state == ST_STREAM) begin
                if (!loaded) begin
                    addr         <= base_addr;
                    f_tree       <= '0;
                    f_param      <= '0;
                    loaded       <= 1'b1;
                    fetch_active <= 1'b1;
                end
                if (advance) begin
                    o_valid        <= 1'b1;
                    o_stage_index  <= f_stage;
                    o_tree_index   <= f_tree;
                    o_param_index  <= f_param;
                    o_is_threshold <= f_thr;
                    o_end_tree     <= f_end_tree;
                    o_end_stage    <= f_end_stage;
                    addr           <= addr + 1'b1;
                    if (f_end_stage) begin
                        f_param <= '0;
                        f_tree  <= '0;
                        if (f_stage == last_stage) begin
                            fetch_active <= 1'b0;
                        end else begin
                            f_stage <= f_stage + 1'b1;
                        end
                    end else if (f_end_tree) begin
                        f_param <= '0;
                        f_tree  <= f_tree + 1'b1;
                    end else begin
                        f_param <= f_param + 1'b1;
                    end
                end else if (o_valid && i_ready) begin
                    o_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_haar_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_haar_stage_sequencer
// Scoreboard bench for haar_stage_sequencer with a small cascade
// (2 stages, 2 trees of 3 words, 1 threshold word; ROM word k = 100+k).
// -----------------------------------------------------------------------------
module tb_haar_stage_sequencer;

    localparam int AWI = 10;
    localparam int DW  = 12;
    localparam int NS  = 2;
    localparam int NC  = 2;
    localparam int NP  = 3;
    localparam int NT  = 1;
    localparam int WPS = NC * NP + NT;

    logic           clk_fpga = 1'b0;
    logic           reset_fpga = 1'b0;
    logic           i_start = 1'b0;
    logic [AWI-1:0] i_stage_sel = '0;
    logic           i_single_stage = 1'b0;
    logic           i_abort = 1'b0;
    logic           i_ready = 1'b1;
    logic           o_valid;
    logic [DW-1:0]  o_data;
    logic [AWI-1:0] o_stage_index;
    logic [AWI-1:0] o_tree_index;
    logic [AWI-1:0] o_param_index;
    logic           o_is_threshold;
    logic           o_end_tree;
    logic           o_end_stage;
    logic           o_done;
    logic           o_busy;
    logic           o_err;

    typedef struct {
        logic [DW-1:0]  data;
        logic [AWI-1:0] stage;
        logic [AWI-1:0] tree;
        logic [AWI-1:0] param;
        logic           thr;
        logic           etree;
        logic           estage;
        logic           last;
    } word_t;

    word_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    int          cyc = 0;
    bit          done_due = 1'b0;
    bit          stall_prev = 1'b0;
    logic [63:0] snap = '0;

    always #5 clk_fpga = ~clk_fpga;

    haar_stage_sequencer #(
        .ADDR_WIDTH               (AWI),
        .DATA_WIDTH               (DW),
        .NUM_STAGES               (NS),
        .NUM_CLASSIFIERS_STAGE    (NC),
        .NUM_PARAM_PER_CLASSIFIER (NP),
        .NUM_STAGE_THRESHOLD      (NT),
        .FILE_STAGE_MEM           ("")
    ) dut (
        .clk_fpga       (clk_fpga),
        .reset_fpga     (reset_fpga),
        .i_start        (i_start),
        .i_stage_sel    (i_stage_sel),
        .i_single_stage (i_single_stage),
        .i_abort        (i_abort),
        .i_ready        (i_ready),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .o_stage_index  (o_stage_index),
        .o_tree_index   (o_tree_index),
        .o_param_index  (o_param_index),
        .o_is_threshold (o_is_threshold),
        .o_end_tree     (o_end_tree),
        .o_end_stage    (o_end_stage),
        .o_done         (o_done),
        .o_busy         (o_busy),
        .o_err          (o_err)
    );

    // One comparison: counts it, and reports actual against required on a miss.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: a run is every word from the selected stage to the last
    // requested stage; each stage is laid out as trees of NP words followed by
    // NT threshold words, at linear offset s*WPS+w.
    function automatic void pushRun(input int sel, input bit single);
        int last_s = single ? sel : NS - 1;
        for (int s = sel; s <= last_s; s++) begin
            for (int w = 0; w < WPS; w++) begin
                word_t e;
                e.data  = DW'(100 + s * WPS + w);
                e.stage = AWI'(s);
                if (w < NC * NP) begin
                    e.tree   = AWI'(w / NP);
                    e.param  = AWI'(w % NP);
                    e.thr    = 1'b0;
                    e.etree  = ((w % NP) == NP - 1);
                    e.estage = 1'b0;
                end else begin
                    e.tree   = AWI'(NC);
                    e.param  = AWI'(w - NC * NP);
                    e.thr    = 1'b1;
                    e.etree  = 1'b0;
                    e.estage = (w == WPS - 1);
                end
                e.last = (s == last_s) && (w == WPS - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    // Consumer ready pattern: 0 always ready, 1 the 1,0,0,1 cycle, 2 random.
    always @(posedge clk_fpga) begin
        #1;
        cyc++;
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares each transferred word with the scoreboard head, checks
    // the completion pulse and output stability during stalls.
    always @(negedge clk_fpga) begin
        logic [63:0] obs;
        obs = {18'd0, o_valid, o_data, o_stage_index, o_tree_index, o_param_index,
               o_is_threshold, o_end_tree, o_end_stage};
        if (!reset_fpga) begin
            exp_q.delete();
            done_due   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (done_due) begin
                checkOutput("done_pulse", {o_done, o_valid}, 2'b10);
                done_due = 1'b0;
            end else if (o_done) begin
                checkOutput("unexpected_done", o_done, 1'b0);
            end
            if (stall_prev) begin
                checkOutput("stall_hold", obs, snap);
            end
            stall_prev = o_valid && !i_ready && !i_abort;
            snap = obs;
            if (i_abort) begin
                exp_q.delete();
            end else if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_word: got %0d, expected no word", o_data);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    checkOutput("word",
                        {o_data, o_stage_index, o_tree_index, o_param_index,
                         o_is_threshold, o_end_tree, o_end_stage},
                        {e.data, e.stage, e.tree, e.param, e.thr, e.etree, e.estage});
                    if (e.last) done_due = 1'b1;
                end
            end
        end
    end

    // Issues a start at the current time (just after an edge) and checks the
    // start response: two-cycle latency for a good stage, o_err for a bad one.
    task automatic applyStimulus(input int sel, input bit single);
        if (sel < NS) pushRun(sel, single);
        i_start        = 1'b1;
        i_stage_sel    = AWI'(sel);
        i_single_stage = single;
        @(posedge clk_fpga); #1;
        i_start = 1'b0;
        if (sel < NS) begin
            checkOutput("start_busy", {o_busy, o_valid}, 2'b10);
            @(posedge clk_fpga); #1;
            checkOutput("latency_e1", o_valid, 1'b0);
            @(posedge clk_fpga); #1;
            checkOutput("latency_e2", o_valid, 1'b1);
        end else begin
            checkOutput("bad_err", {o_err, o_busy, o_valid}, 3'b100);
            @(posedge clk_fpga); #1;
            checkOutput("bad_err_clear", {o_err, o_busy, o_valid}, 3'b000);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            @(posedge clk_fpga); #1;
            n++;
        end
        checkOutput("run_complete", o_busy, 1'b0);
        @(posedge clk_fpga); #1;
        checkOutput("words_left", exp_q.size(), 0);
    endtask

    task automatic waitWord(input logic [DW-1:0] val, input int budget);
        int n = 0;
        while (!(o_valid && o_data == val) && n < budget) begin
            @(posedge clk_fpga); #1;
            n++;
        end
        checkOutput("reach_word", {o_valid, o_data}, {1'b1, val});
    endtask

    initial begin
        for (int k = 0; k < NS * WPS; k++) begin
            dut.u_rom.mem[k] = DW'(100 + k);
        end
        repeat (3) @(posedge clk_fpga);
        #1;
        checkOutput("reset_outputs",
            {o_valid, o_data, o_stage_index, o_tree_index, o_param_index,
             o_is_threshold, o_end_tree, o_end_stage, o_done, o_busy, o_err}, '0);

        // Full run started on the first edge after reset release, with a
        // start pulse mid-stream that must be ignored.
        reset_fpga = 1'b1;
        ready_mode = 0;
        applyStimulus(0, 1'b0);
        repeat (3) @(posedge clk_fpga);
        #1;
        i_start = 1'b1; i_stage_sel = AWI'(1); i_single_stage = 1'b1;
        @(posedge clk_fpga); #1;
        i_start = 1'b0;
        waitIdle(100);

        $display("[TB] single stage");
        applyStimulus(1, 1'b1);
        waitIdle(100);

        $display("[TB] backpressure 1,0,0,1");
        ready_mode = 1;
        applyStimulus(0, 1'b0);
        waitIdle(200);
        ready_mode = 0;

        $display("[TB] bad stage");
        applyStimulus(2, 1'b0);
        repeat (4) @(posedge clk_fpga);
        #1;
        checkOutput("bad_stays_idle", {o_busy, o_valid}, 2'b00);

        $display("[TB] abort");
        applyStimulus(0, 1'b0);
        waitWord(12'd104, 20);
        i_abort = 1'b1;
        @(posedge clk_fpga); #1;
        i_abort = 1'b0;
        checkOutput("abort_idle", {o_valid, o_busy, o_done}, 3'b000);
        repeat (3) @(posedge clk_fpga);
        #1;
        applyStimulus(0, 1'b0);
        waitIdle(100);

        $display("[TB] reset mid-stream");
        applyStimulus(0, 1'b0);
        waitWord(12'd107, 20);
        reset_fpga = 1'b0;
        #1;
        checkOutput("reset_async",
            {o_valid, o_data, o_stage_index, o_tree_index, o_param_index,
             o_is_threshold, o_end_tree, o_end_stage, o_done, o_busy, o_err}, '0);
        @(posedge clk_fpga); #1;
        reset_fpga = 1'b1;
        applyStimulus(0, 1'b0);
        waitIdle(100);

        $display("[TB] random runs");
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            int sel;
            bit single;
            sel    = int'($urandom_range(0, NS));
            single = 1'($urandom_range(0, 1));
            applyStimulus(sel, single);
            if (sel < NS) waitIdle(300);
            @(posedge clk_fpga); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/haar_stage_sequencer.md
HAAR_STAGE_SEQUENCER -- requirements
Module: haar_stage_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, stage-memory address and index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, memory word width.
REQ-003 SHALL have parameter NUM_STAGES, default 4, number of cascade stages held in memory.
REQ-004 SHALL have parameter NUM_CLASSIFIERS_STAGE, default 10, trees per stage.
REQ-005 SHALL have parameter NUM_PARAM_PER_CLASSIFIER, default 19, words per tree.
REQ-006 SHALL have parameter NUM_STAGE_THRESHOLD, default 3, threshold words per stage.
REQ-007 SHALL have parameter FILE_STAGE_MEM, default "memory.mif", memory init file.
REQ-008 SHALL have port clk_fpga, input, 1, sole clock; all logic rising-edge.
REQ-009 SHALL have port reset_fpga, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port i_start, input, 1, start request, sampled in IDLE only.
REQ-011 SHALL have port i_stage_sel, input, ADDR_WIDTH, first stage to stream, captured on accepted start.
REQ-012 SHALL have port i_single_stage, input, 1, 1 = stream only the selected stage; 0 = stream the selected stage through NUM_STAGES-1; captured on accepted start.
REQ-013 SHALL have port i_abort, input, 1, synchronous abort.
REQ-014 SHALL have port i_ready, input, 1, consumer accepts o_data.
REQ-015 SHALL have the following outputs:
- o_valid, 1: o_data is valid.
- o_data, DATA_WIDTH: parameter word.
- o_stage_index, ADDR_WIDTH: stage of the current word.
- o_tree_index, ADDR_WIDTH: tree of the current word.
- o_param_index, ADDR_WIDTH: word offset within the tree or threshold group.
- o_is_threshold, 1: word is a stage threshold.
- o_end_tree, 1: last word of a tree.
- o_end_stage, 1: last word of a stage.
- o_done, 1: completion pulse.
- o_busy, 1: not IDLE.
- o_err, 1: start rejected.

Function
REQ-016 SHALL derive WORDS_PER_STAGE = NUM_CLASSIFIERS_STAGE*NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD; the base address of stage s SHALL be s*WORDS_PER_STAGE.
REQ-017 SHALL order each stage as: tree 0 words 0..P-1, tree 1, ... up to tree C-1, then threshold words 0..T-1.
REQ-018 SHALL, for threshold words, drive o_is_threshold=1, o_tree_index=NUM_CLASSIFIERS_STAGE and o_end_tree=0; o_end_stage=1 on threshold word T-1.
REQ-019 SHALL implement the FSM IDLE -> STREAM -> DONE -> IDLE.
REQ-020 SHALL leave IDLE only on i_start=1, i_abort=0 and i_stage_sel<NUM_STAGES.
REQ-021 SHALL, when i_start=1 and i_stage_sel>=NUM_STAGES in IDLE, pulse o_err for 1 cycle and stay in IDLE.
REQ-022 SHALL ignore i_start outside IDLE.
REQ-023 SHALL read memory with 1-cycle registered latency and first assert o_valid 2 cycles after the accepted-start edge.
REQ-024 SHALL complete a transfer on the edge where o_valid=1 and i_ready=1.
REQ-025 SHALL sustain one word per cycle while i_ready=1, with no bubbles at tree or stage boundaries.
REQ-026 SHALL hold o_data and all index/flag outputs stable while o_valid=1 and i_ready=0.
REQ-027 SHALL never advance the memory address while a held word is unaccepted.
REQ-028 SHALL, after the final word of the final stage transfers, deassert o_valid next cycle, enter DONE and pulse o_done for exactly 1 cycle, then return to IDLE.
REQ-029 SHALL, on i_abort=1 in any state, go to IDLE next cycle with o_valid=0 and no o_done; abort wins over simultaneous start or transfer.
REQ-030 SHALL keep o_busy=1 in STREAM and DONE.
REQ-031 SHALL size the internal address counter to ceil(log2(NUM_STAGES*WORDS_PER_STAGE)) bits; index counters SHALL wrap to 0 at their terminal count.

Reset
REQ-032 SHALL, while reset_fpga=0, immediately force IDLE and drive o_valid, o_data, all indices, o_is_threshold, o_end_tree, o_end_stage, o_done, o_busy and o_err to 0, including mid-stream.
REQ-033 SHALL, after reset release, accept i_start on the first clock edge.

Structure
REQ-034 SHALL place the FSM state encoding and a WORDS_PER_STAGE/address-width derivation helper in a shared package haar_pkg.
REQ-035 SHALL instantiate one sub-module, stage_rom (synchronous single-port ROM, FILE_STAGE_MEM init, read-enable, 1-cycle latency).

Verification
Bench parameters: NUM_STAGES=2, C=2, P=3, T=1 (7 words/stage); memory word k = 100+k.

REQ-036 SHALL cover full run: start with sel=0, single=0, i_ready=1 -> 14 consecutive valid words 100..113. Markers:
- o_end_tree on words 102, 105, 109, 112.
- o_end_stage on 106 and 113.
- o_done 1 cycle after 113.
REQ-037 SHALL cover single stage: start with sel=1, single=1 -> words 107..113 only, o_stage_index=1, word 113 has o_is_threshold=1 and o_tree_index=2.
REQ-038 SHALL cover backpressure: i_ready toggles 1,0,0,1 repeating -> same 14-word sequence, no loss or duplicate, outputs stable during stalls.
REQ-039 SHALL cover a bad stage: start with sel=2 -> o_err pulse, o_busy stays 0, o_valid never asserts.
REQ-040 SHALL cover abort: assert i_abort on the 5th valid word -> o_valid=0 and o_busy=0 next cycle, no o_done; a following start with sel=0 restarts at word 100.
REQ-041 SHALL cover reset mid-stream: drive reset_fpga low at word 8 -> all outputs 0 immediately; after release, a start with sel=0 yields word 100 two cycles later.
